// File: rtl/perf_counter_bank_if.sv
// Software-side access bundle for perf_counter_bank: registered read port plus threshold writes.
// The master issues requests; the counter bank answers one cycle later and never stalls.
interface perf_counter_bank_if #(
  parameter int NUM_CNT = 16,
  parameter int CNT_W   = 48,
  parameter int SEL_W   = $clog2(NUM_CNT)
);
  logic             rd_req;
  logic [SEL_W-1:0] rd_sel;
  logic             rd_shadow;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             rd_err;

  logic             thr_wr;
  logic [SEL_W-1:0] thr_sel;
  logic [CNT_W-1:0] thr_val;

  modport master (
    output rd_req, rd_sel, rd_shadow, thr_wr, thr_sel, thr_val,
    input  rd_valid, rd_data, rd_err
  );

  modport slave (
    input  rd_req, rd_sel, rd_shadow, thr_wr, thr_sel, thr_val,
    output rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of saturating/wrapping event counters with sticky overflow, threshold irq and snapshot shadow.
// Counts land one cycle after the increment; reads return one cycle after rd_req, one per cycle, no backpressure.
module perf_counter_bank #(
  parameter int NUM_CNT = 16,
  parameter int CNT_W   = 48,
  parameter int INC_W   = 4,
  parameter int SEL_W   = $clog2(NUM_CNT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cnt_en,
  input  logic [NUM_CNT*INC_W-1:0] i_inc_val,
  input  logic [NUM_CNT-1:0]       i_wrap_mode,
  input  logic                     i_clear,
  input  logic                     i_snapshot,
  input  logic [NUM_CNT-1:0]       i_irq_clr,
  perf_counter_bank_if.slave       bus,
  output logic [NUM_CNT-1:0]       o_ovf,
  output logic [NUM_CNT-1:0]       o_irq_status,
  output logic                     o_irq
);

  logic [CNT_W-1:0] w_live   [NUM_CNT];
  logic [CNT_W-1:0] w_shadow [NUM_CNT];
  logic [SEL_W:0]   w_rd_sel_ext;
  logic             w_rd_oob;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_thr;
    logic             r_ovf;
    logic             r_irq_st;
    logic [INC_W-1:0] w_inc;
    logic [CNT_W:0]   w_sum;
    logic             w_bump;
    logic [CNT_W-1:0] w_nxt;
    logic             w_irq_set;

    assign w_inc  = i_inc_val[i*INC_W +: INC_W];
    assign w_bump = i_cnt_en && (w_inc != '0);
    assign w_sum  = {1'b0, r_cnt} + (CNT_W+1)'(w_inc);

    always_comb begin
      w_nxt = r_cnt;
      if (i_clear) begin
        w_nxt = '0;
      end else if (w_bump) begin
        if (w_sum[CNT_W] && !i_wrap_mode[i]) begin
          w_nxt = '1;
        end else begin
          w_nxt = w_sum[CNT_W-1:0];
        end
      end
    end

    // A clear can never cross a nonzero threshold, so it is excluded explicitly only for clarity.
    assign w_irq_set = !i_clear && (r_thr != '0) && (r_cnt < r_thr) && (w_nxt >= r_thr);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt    <= '0;
        r_shadow <= '0;
        r_thr    <= '0;
        r_ovf    <= 1'b0;
        r_irq_st <= 1'b0;
      end else begin
        r_cnt <= w_nxt;
        if (i_clear) begin
          r_ovf <= 1'b0;
        end else if (w_bump && w_sum[CNT_W]) begin
          r_ovf <= 1'b1;
        end
        if (i_snapshot) begin
          r_shadow <= r_cnt;
        end
        if (bus.thr_wr && (bus.thr_sel == SEL_W'(i))) begin
          r_thr <= bus.thr_val;
        end
        r_irq_st <= (r_irq_st && !i_irq_clr[i]) || w_irq_set;
      end
    end

    assign w_live[i]       = r_cnt;
    assign w_shadow[i]     = r_shadow;
    assign o_ovf[i]        = r_ovf;
    assign o_irq_status[i] = r_irq_st;
  end

  assign w_rd_sel_ext = {1'b0, bus.rd_sel};
  assign w_rd_oob     = (w_rd_sel_ext >= (SEL_W+1)'(NUM_CNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.rd_err   <= 1'b0;
      o_irq        <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_req;
      o_irq        <= |o_irq_status;
      if (bus.rd_req) begin
        bus.rd_err <= w_rd_oob;
        if (w_rd_oob) begin
          bus.rd_data <= '0;
        end else if (bus.rd_shadow) begin
          bus.rd_data <= w_shadow[bus.rd_sel];
        end else begin
          bus.rd_data <= w_live[bus.rd_sel];
        end
      end else begin
        bus.rd_err <= 1'b0;
      end
    end
  end

endmodule
